// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the sequenced multiply-accumulate controller:
// FSM encoding and DSP slice post-adder OPMODE values.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // OPMODE: X=M, Z=0 starts a sum; X=M, Z=P accumulates onto P.
    localparam logic [7:0] OPM_IDLE = 8'h00;
    localparam logic [7:0] OPM_MUL  = 8'h01;
    localparam logic [7:0] OPM_MAC  = 8'h09;

endpackage

// File: rtl/dsp_flag_pipe.sv
// Shift register of per-operand control flags that tracks pairs through the
// slice multiplier. The MSB of each entry is its valid bit.
module dsp_flag_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             occupied
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < DEPTH; i++) occupied = occupied | pipe[i][WIDTH-1];
    end

endmodule

// File: rtl/dsp_mac_seq.sv
// Job sequencer that streams operand pairs into an external DSP slice and
// returns the accumulated P value once the last product has landed.
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W    = 10,
    parameter int MULT_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [17:0] s_a,
    input  logic signed [17:0] s_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [47:0]        res_data,
    output logic               busy,
    output logic [17:0]        dsp_a,
    output logic [17:0]        dsp_b,
    output logic [7:0]         dsp_opmode,
    output logic               dsp_ce_p,
    input  logic [47:0]        dsp_p
);

    // One extra stage covers the operand register in front of the multiplier.
    localparam int DEPTH = MULT_LAT + 1;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic             s_hs;
    logic [1:0]       flag_d;
    logic [1:0]       flag_q;
    logic             in_flight;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign s_ready   = (state == RUN) && (remaining != '0);
    assign s_hs      = s_valid && s_ready;
    assign flag_d    = {s_hs, s_hs && first};

    dsp_flag_pipe #(
        .DEPTH(DEPTH),
        .WIDTH(2)
    ) u_flags (
        .clk      (clk),
        .rst      (rst),
        .d        (flag_d),
        .q        (flag_q),
        .occupied (in_flight)
    );

    assign dsp_ce_p   = flag_q[1];
    assign dsp_opmode = !flag_q[1] ? OPM_IDLE : (flag_q[0] ? OPM_MUL : OPM_MAC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            first     <= 1'b0;
            dsp_a     <= '0;
            dsp_b     <= '0;
            res_data  <= '0;
        end else begin
            if (s_hs) begin
                dsp_a     <= s_a;
                dsp_b     <= s_b;
                remaining <= remaining - 1'b1;
                first     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len != '0) begin
                            remaining <= cmd_len;
                            first     <= 1'b1;
                            state     <= RUN;
                        end else begin
                            res_data <= '0;
                            state    <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (s_hs && remaining == LEN_W'(1)) state <= DRAIN;
                end
                // Pipe empty means the final ce_p edge has already updated P.
                DRAIN: begin
                    if (!in_flight) begin
                        res_data <= dsp_p;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP slice (MULT_LAT
// product stages plus a P accumulator) closing the loop on dsp_p.
module tb_dsp_mac_seq;

    localparam int LEN_W    = 10;
    localparam int MULT_LAT = 2;

    logic               clk = 0;
    logic               rst = 1;
    logic               cmd_valid = 0;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic               s_valid = 0;
    logic               s_ready;
    logic signed [17:0] s_a = '0;
    logic signed [17:0] s_b = '0;
    logic               res_valid;
    logic               res_ready = 0;
    logic [47:0]        res_data;
    logic               busy;
    logic [17:0]        dsp_a;
    logic [17:0]        dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_ce_p;
    logic [47:0]        dsp_p;

    dsp_mac_seq #(.LEN_W(LEN_W), .MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .dsp_a(dsp_a), .dsp_b(dsp_b),
        .dsp_opmode(dsp_opmode), .dsp_ce_p(dsp_ce_p), .dsp_p(dsp_p)
    );

    always #5 clk = ~clk;

    // Slice model: product reaches the post-adder MULT_LAT edges after dsp_a/b.
    logic signed [47:0] mreg [MULT_LAT];
    logic signed [47:0] p_reg;
    int cyc = 0;
    int ce_tot = 0;

    initial begin
        p_reg = '0;
        for (int i = 0; i < MULT_LAT; i++) mreg[i] = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dsp_ce_p) ce_tot <= ce_tot + 1;
        mreg[0] <= $signed(dsp_a) * $signed(dsp_b);
        for (int i = 1; i < MULT_LAT; i++) mreg[i] <= mreg[i-1];
        if (dsp_ce_p)
            p_reg <= ((dsp_opmode == 8'h09) ? p_reg : 48'sd0) + mreg[MULT_LAT-1];
    end
    assign dsp_p = p_reg;

    int nvec = 0;
    int nmis = 0;
    int last_acc;
    int res_cyc;
    logic [47:0] res_got;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input int len);
        int n = 0;
        cmd_valid = 1;
        cmd_len = LEN_W'(len);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_timeout", 48'(n < 50), 48'd1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic send_pair(input int a, input int b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        s_valid = 1;
        s_a = 18'(a);
        s_b = 18'(b);
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        chk("s_timeout", 48'(n < 50), 48'd1);
        last_acc = cyc;
        @(negedge clk);
        s_valid = 0;
    endtask

    task automatic wait_res(input bit ack);
        int n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        chk("res_timeout", 48'(n < 50), 48'd1);
        res_cyc = cyc;
        res_got = res_data;
        if (ack) begin
            res_ready = 1;
            @(negedge clk);
            res_ready = 0;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_dsp_a"}, 48'(dsp_a), 48'd0);
        chk({tag, "_dsp_b"}, 48'(dsp_b), 48'd0);
        chk({tag, "_opmode"}, 48'(dsp_opmode), 48'd0);
        chk({tag, "_ce_p"}, 48'(dsp_ce_p), 48'd0);
        chk({tag, "_res_valid"}, 48'(res_valid), 48'd0);
        chk({tag, "_res_data"}, res_data, 48'd0);
        chk({tag, "_busy"}, 48'(busy), 48'd0);
        chk({tag, "_s_ready"}, 48'(s_ready), 48'd0);
        chk({tag, "_cmd_ready"}, 48'(cmd_ready), 48'd1);
    endtask

    initial begin
        int ce0;
        logic [47:0] held;

        repeat (3) @(negedge clk);
        chk_reset_outs("rst0");
        rst = 0;
        @(negedge clk);

        // len=3 back-to-back: 6 - 20 - 7 = -21, result 5 cycles after last accept
        ce0 = ce_tot;
        send_cmd(3);
        send_pair(2, 3, 0);
        send_pair(-4, 5, 0);
        send_pair(7, -1, 0);
        wait_res(1);
        chk("len3_sum", res_got, -48'sd21);
        chk("len3_latency", 48'(res_cyc - last_acc), 48'd5);
        chk("len3_ce_cnt", 48'(ce_tot - ce0), 48'd3);

        // len=0: immediate empty result, slice untouched
        ce0 = ce_tot;
        send_cmd(0);
        chk("len0_valid", 48'(res_valid), 48'd1);
        chk("len0_data", res_data, 48'd0);
        wait_res(1);
        repeat (3) @(negedge clk);
        chk("len0_ce_cnt", 48'(ce_tot - ce0), 48'd0);

        // len=4 gapless then with 2-cycle gaps: 6 - 20 - 7 + 100 = 79
        send_cmd(4);
        send_pair(2, 3, 0);
        send_pair(-4, 5, 0);
        send_pair(7, -1, 0);
        send_pair(10, 10, 0);
        wait_res(1);
        chk("len4_sum", res_got, 48'd79);
        ce0 = ce_tot;
        send_cmd(4);
        send_pair(2, 3, 2);
        send_pair(-4, 5, 2);
        send_pair(7, -1, 2);
        send_pair(10, 10, 2);
        wait_res(1);
        chk("len4_gap_sum", res_got, 48'd79);
        chk("len4_gap_ce_cnt", 48'(ce_tot - ce0), 48'd4);

        // Backpressure on the result; a second command must be ignored
        send_cmd(1);
        send_pair(-5, 6, 0);
        wait_res(0);
        held = res_data;
        chk("bp_data", held, -48'sd30);
        cmd_valid = 1;
        cmd_len = LEN_W'(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res_valid", 48'(res_valid), 48'd1);
            chk("bp_res_data", res_data, held);
            chk("bp_cmd_ready", 48'(cmd_ready), 48'd0);
        end
        cmd_valid = 0;
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("bp_idle_busy", 48'(busy), 48'd0);
        chk("bp_idle_cmd_ready", 48'(cmd_ready), 48'd1);
        @(negedge clk);
        chk("bp_no_second_job", 48'(busy), 48'd0);

        // Reset mid-RUN after 2 of 5 pairs
        send_cmd(5);
        send_pair(4, 4, 0);
        send_pair(9, 9, 0);
        chk("mid_busy", 48'(busy), 48'd1);
        rst = 1;
        @(negedge clk);
        chk_reset_outs("rst_mid");
        rst = 0;
        ce0 = ce_tot;
        repeat (8) @(negedge clk);
        chk("post_rst_ce_cnt", 48'(ce_tot - ce0), 48'd0);
        chk("post_rst_res_valid", 48'(res_valid), 48'd0);
        send_cmd(1);
        send_pair(3, 3, 0);
        wait_res(1);
        chk("post_rst_job", res_got, 48'd9);

        // Largest positive operands: 2*131071^2 with no wrap
        send_cmd(2);
        send_pair(131071, 131071, 0);
        send_pair(131071, 131071, 0);
        wait_res(1);
        chk("max_sum", res_got, 48'd34359214082);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
